// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   localparam int XLEN_DEFAULT = 32;

   // op_mul_i encodings
   localparam logic [1:0] MUL_MUL    = 2'b00;
   localparam logic [1:0] MUL_MULH   = 2'b01;
   localparam logic [1:0] MUL_MULHSU = 2'b10;
   localparam logic [1:0] MUL_MULHU  = 2'b11;

   // op_div_i encodings
   localparam logic [1:0] DIV_DIV  = 2'b00;
   localparam logic [1:0] DIV_DIVU = 2'b01;
   localparam logic [1:0] DIV_REM  = 2'b10;
   localparam logic [1:0] DIV_REMU = 2'b11;

   // Fast-path quotients: divide by zero, and signed overflow (-2^31 / -1)
   localparam logic [31:0] DIV0_Q = 32'hFFFF_FFFF;
   localparam logic [31:0] OVF_Q  = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // DIV and REM are the signed divide flavours
   function automatic logic div_is_signed(input logic [1:0] op_div);
      return (op_div == DIV_DIV) || (op_div == DIV_REM);
   endfunction

   // REM and REMU return the remainder instead of the quotient
   function automatic logic div_is_rem(input logic [1:0] op_div);
      return (op_div == DIV_REM) || (op_div == DIV_REMU);
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Sign handling around the magnitude-only datapath: operand magnitudes and
// sign flags on the way in, two's-complement negation of the raw result on
// the way out. The same block serves both ends of the unit.
module muldiv_signfix
   import muldiv_pkg::*;
#(
   parameter int W = XLEN_DEFAULT
) (
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   input  logic           sel_i,
   input  logic [1:0]     op_mul_i,
   input  logic [1:0]     op_div_i,
   input  logic [2*W-1:0] raw_i,
   input  logic           neg_i,
   output logic [W-1:0]   mag_a_o,
   output logic [W-1:0]   mag_b_o,
   output logic           sa_o,
   output logic           sb_o,
   output logic [2*W-1:0] res_o
);

   logic a_signed;
   logic b_signed;

   // Decide operand signedness, strip signs, and optionally negate the result
   always_comb begin
      a_signed = sel_i ? div_is_signed(op_div_i) : (op_mul_i != MUL_MULHU);
      b_signed = sel_i ? div_is_signed(op_div_i)
                       : ((op_mul_i == MUL_MUL) || (op_mul_i == MUL_MULH));
      sa_o     = a_signed & a_i[W-1];
      sb_o     = b_signed & b_i[W-1];
      mag_a_o  = sa_o ? -a_i : a_i;
      mag_b_o  = sb_o ? -b_i : b_i;
      res_o    = neg_i ? -raw_i : raw_i;
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 shift-add / restoring
// divide step per cycle on operand magnitudes, sign fix-up at the end,
// fast paths for divide-by-zero and signed overflow.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int CNT_W = 6
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            start_i,
   input  logic            sel_i,
   input  logic [1:0]      op_mul_i,
   input  logic [1:0]      op_div_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   // acc: multiply = {partial product hi, multiplier/product lo};
   //      divide   = {partial remainder, dividend/quotient}
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              sel_q, sel_d;
   logic [1:0]        op_mul_q, op_mul_d;
   logic [1:0]        op_div_q, op_div_d;
   logic              sa_q, sa_d;
   logic              sb_q, sb_d;

   logic [XLEN-1:0]   mag_a, mag_b;
   logic              sa_in, sb_in;
   logic [2*XLEN-1:0] in_res_unused;
   logic [XLEN-1:0]   out_mag_a, out_mag_b;
   logic              out_sa, out_sb;

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shl;
   logic [XLEN+1:0]   div_diff;
   logic [2*XLEN-1:0] acc_step;
   logic [2*XLEN-1:0] raw_out;
   logic              neg_out;
   logic [2*XLEN-1:0] res_fix;
   logic [XLEN-1:0]   final_res;
   logic              div0, ovf;
   logic [XLEN-1:0]   fast_res;

   muldiv_signfix #(.W(XLEN)) u_fix_in (
      .a_i      (a_i),
      .b_i      (b_i),
      .sel_i    (sel_i),
      .op_mul_i (op_mul_i),
      .op_div_i (op_div_i),
      .raw_i    ('0),
      .neg_i    (1'b0),
      .mag_a_o  (mag_a),
      .mag_b_o  (mag_b),
      .sa_o     (sa_in),
      .sb_o     (sb_in),
      .res_o    (in_res_unused)
   );

   muldiv_signfix #(.W(XLEN)) u_fix_out (
      .a_i      ('0),
      .b_i      ('0),
      .sel_i    (sel_q),
      .op_mul_i (op_mul_q),
      .op_div_i (op_div_q),
      .raw_i    (raw_out),
      .neg_i    (neg_out),
      .mag_a_o  (out_mag_a),
      .mag_b_o  (out_mag_b),
      .sa_o     (out_sa),
      .sb_o     (out_sb),
      .res_o    (res_fix)
   );

   // One datapath iteration plus selection of the sign-corrected final result
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
      div_shl  = acc_q[2*XLEN-1:XLEN-1];
      div_diff = {1'b0, div_shl} - {2'b00, b_q};
      if (!sel_q) begin
         acc_step = {mul_sum, acc_q[XLEN-1:1]};
      end else if (!div_diff[XLEN+1]) begin
         acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
         acc_step = {div_shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
      if (sel_q) begin
         raw_out = {{XLEN{1'b0}},
                    div_is_rem(op_div_q) ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0]};
         neg_out = div_is_rem(op_div_q) ? sa_q : (sa_q ^ sb_q);
      end else begin
         raw_out = acc_step;
         neg_out = sa_q ^ sb_q;
      end
      final_res = (sel_q || (op_mul_q == MUL_MUL)) ? res_fix[XLEN-1:0]
                                                   : res_fix[2*XLEN-1:XLEN];
   end

   // Divide corner cases that bypass iteration entirely
   always_comb begin
      div0 = sel_i && (b_i == '0);
      ovf  = sel_i && div_is_signed(op_div_i) && (a_i == OVF_Q) && (b_i == '1);
      if (div0) begin
         fast_res = div_is_rem(op_div_i) ? a_i : DIV0_Q;
      end else begin
         fast_res = div_is_rem(op_div_i) ? '0 : OVF_Q;
      end
   end

   // Next-state, datapath load/step and handshake outputs
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      b_d      = b_q;
      result_d = result_q;
      sel_d    = sel_q;
      op_mul_d = op_mul_q;
      op_div_d = op_div_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      busy_o   = 1'b0;
      done_o   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i && !flush_i) begin
               busy_o   = 1'b1;
               sel_d    = sel_i;
               op_mul_d = op_mul_i;
               op_div_d = op_div_i;
               sa_d     = sa_in;
               sb_d     = sb_in;
               cnt_d    = '0;
               if (div0 || ovf) begin
                  state_d  = DONE;
                  result_d = fast_res;
               end else begin
                  state_d = BUSY;
                  acc_d   = {{XLEN{1'b0}}, mag_a};
                  b_d     = mag_b;
               end
            end
         end
         BUSY: begin
            busy_o = 1'b1;
            if (flush_i) begin
               state_d = IDLE;
            end else begin
               acc_d = acc_step;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  state_d  = DONE;
                  result_d = final_res;
               end
            end
         end
         DONE: begin
            done_o  = !flush_i;
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         b_q      <= '0;
         result_q <= '0;
         sel_q    <= 1'b0;
         op_mul_q <= '0;
         op_div_q <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         b_q      <= b_d;
         result_q <= result_d;
         sel_q    <= sel_d;
         op_mul_q <= op_mul_d;
         op_div_q <= op_div_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
      end
   end

   assign result_o = result_q;

   // Outputs of the shared sign block that one side or the other never needs
   logic unused_ok;
   assign unused_ok = ^{in_res_unused, out_mag_a, out_mag_b, out_sa, out_sb, div_diff[XLEN]};

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic model of the RV32M rules,
// a result scoreboard checked every cycle, and latency/handshake checks.
module tb_muldiv_unit;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        start_i = 1'b0;
   logic        sel_i = 1'b0;
   logic [1:0]  op_mul_i = 2'b00;
   logic [1:0]  op_div_i = 2'b00;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        flush_i = 1'b0;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;

   int          vectors = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] model_res = '0;

   muldiv_unit dut (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .start_i  (start_i),
      .sel_i    (sel_i),
      .op_mul_i (op_mul_i),
      .op_div_i (op_div_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .flush_i  (flush_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   // Clock
   always #5 clk_i = ~clk_i;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // RV32M result from the ISA rules, using plain 64-bit and signed arithmetic
   function automatic logic [31:0] model(input logic s, input logic [1:0] om,
                                         input logic [1:0] od, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] ea, eb, p;
      logic        sgn;
      if (!s) begin
         ea = (om != 2'b11) ? {{32{a[31]}}, a} : {32'h0, a};
         eb = (om == 2'b00 || om == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
         p  = ea * eb;
         return (om == 2'b00) ? p[31:0] : p[63:32];
      end
      sgn = !od[0];
      if (b == 32'h0) return od[1] ? a : 32'hFFFF_FFFF;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return od[1] ? 32'h0 : 32'h8000_0000;
      if (sgn) return od[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
      return od[1] ? a % b : a / b;
   endfunction

   function automatic int model_lat(input logic s, input logic [1:0] od,
                                    input logic [31:0] a, input logic [31:0] b);
      if (s && (b == 32'h0 || (!od[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
      return 33;
   endfunction

   // Scoreboard: on each done pulse the next expected result becomes the
   // value result_o must hold until the following done
   always @(negedge clk_i) begin
      if (!reset_i) begin
         if (done_o) begin
            if (exp_q.size() == 0) check("unexpected_done", {31'h0, done_o}, 32'h0);
            else model_res = exp_q.pop_front();
         end
         check("result_o", result_o, model_res);
      end
   end

   // Driver: present an op at the start of a cycle (cycle 0)
   task automatic issue(input logic s, input logic [1:0] om, input logic [1:0] od,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      @(negedge clk_i);
      sel_i = s; op_mul_i = om; op_div_i = od; a_i = a; b_i = b;
      start_i = 1'b1;
      exp_q.push_back(exp);
   endtask

   // Wait for done_o, counting cycles from the current one
   task automatic wait_done(input string name, input int exp_lat, input bit chk_busy);
      int  n = 0;
      bit  seen = 0;
      if (chk_busy) begin
         #1;
         check({name, "_busy_c0"}, {31'h0, busy_o}, 32'h1);
      end
      while (n < 45 && !seen) begin
         @(negedge clk_i);
         n++;
         if (done_o) seen = 1;
         else if (chk_busy) check({name, "_busy"}, {31'h0, busy_o}, 32'h1);
      end
      if (!seen) begin
         check({name, "_timeout"}, 32'h0, 32'h1);
      end else begin
         check({name, "_latency"}, n, exp_lat);
         check({name, "_busy_done"}, {31'h0, busy_o}, 32'h0);
      end
   endtask

   task automatic run_vec(input string name, input logic s, input logic [1:0] om,
                          input logic [1:0] od, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit chk_busy);
      check({"pin_", name}, model(s, om, od, a, b), exp);
      issue(s, om, od, a, b, exp);
      wait_done(name, model_lat(s, od, a, b), chk_busy);
      a_i = $urandom; b_i = $urandom;
      start_i = 1'b0;
   endtask

   task automatic run_model(input string name, input logic s, input logic [1:0] om,
                            input logic [1:0] od, input logic [31:0] a, input logic [31:0] b);
      issue(s, om, od, a, b, model(s, om, od, a, b));
      wait_done(name, model_lat(s, od, a, b), 1'b0);
      start_i = 1'b0;
   endtask

   initial begin
      int  n;
      bit  seen;
      // Reset state
      #1;
      check("reset_result", result_o, 32'h0);
      check("reset_done", {31'h0, done_o}, 32'h0);
      check("reset_busy", {31'h0, busy_o}, 32'h0);
      repeat (3) @(negedge clk_i);
      reset_i = 1'b0;

      // Multiply
      run_vec("mul_7_m3",    1'b0, 2'b00, 2'b00, 32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
      run_vec("mulh_min",    1'b0, 2'b01, 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
      run_vec("mulhu_max",   1'b0, 2'b11, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      run_vec("mulhsu_m1_2", 1'b0, 2'b10, 2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0);
      // Divide
      run_vec("div_m7_2",    1'b1, 2'b00, 2'b00, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 1'b0);
      run_vec("rem_m7_2",    1'b1, 2'b00, 2'b10, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 1'b0);
      run_vec("divu_100_7",  1'b1, 2'b00, 2'b01, 32'd100,       32'd7,         32'd14,        1'b0);
      run_vec("remu_100_7",  1'b1, 2'b00, 2'b11, 32'd100,       32'd7,         32'd2,         1'b0);
      // Fast paths
      run_vec("divu_by0",    1'b1, 2'b00, 2'b01, 32'd5,         32'h0,         32'hFFFF_FFFF, 1'b1);
      run_vec("rem_by0",     1'b1, 2'b00, 2'b10, 32'd5,         32'h0,         32'd5,         1'b0);
      run_vec("div_ovf",     1'b1, 2'b00, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
      run_vec("rem_ovf",     1'b1, 2'b00, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0);
      // More operand patterns, expected values from the model
      run_model("mul_big",    1'b0, 2'b00, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
      run_model("mulh_m5_7",  1'b0, 2'b01, 2'b00, 32'hFFFF_FFFB, 32'h7);
      run_model("mulhsu_min", 1'b0, 2'b10, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
      run_model("div_min_3",  1'b1, 2'b00, 2'b00, 32'h8000_0000, 32'h3);
      run_model("rem_7_m2",   1'b1, 2'b00, 2'b10, 32'h7,         32'hFFFF_FFFE);
      run_model("divu_ovfop", 1'b1, 2'b00, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
      run_model("remu_max",   1'b1, 2'b00, 2'b11, 32'hFFFF_FFFF, 32'h10);

      // Back-to-back: start_i stays high across the first done
      issue(1'b0, 2'b00, 2'b00, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001);
      wait_done("b2b_mul", 33, 1'b1);
      sel_i = 1'b1; op_div_i = 2'b00; a_i = 32'd1000; b_i = 32'hFFFF_FFF6;
      exp_q.push_back(32'hFFFF_FF9C);
      wait_done("b2b_div", 34, 1'b0);
      start_i = 1'b0;

      // Flush in IDLE blocks acceptance
      @(negedge clk_i);
      start_i = 1'b1; flush_i = 1'b1; sel_i = 1'b0; a_i = 32'd9; b_i = 32'd9;
      #1;
      check("flush_idle_busy", {31'h0, busy_o}, 32'h0);
      @(negedge clk_i);
      start_i = 1'b0; flush_i = 1'b0;
      #1;
      check("flush_idle_stay", {31'h0, busy_o}, 32'h0);

      // Flush at cycle 10 of a divide: no done, result unchanged
      @(negedge clk_i);
      sel_i = 1'b1; op_div_i = 2'b01; a_i = 32'd1234; b_i = 32'd11; start_i = 1'b1;
      repeat (10) @(negedge clk_i);
      flush_i = 1'b1; start_i = 1'b0;
      @(negedge clk_i);
      flush_i = 1'b0;
      check("flush_busy_idle", {31'h0, busy_o}, 32'h0);
      n = 0; seen = 0;
      while (n < 40) begin
         @(negedge clk_i);
         n++;
         if (done_o) seen = 1;
      end
      check("flush_no_done", {31'h0, seen}, 32'h0);
      check("flush_result_kept", result_o, 32'hFFFF_FF9C);

      // Asynchronous reset mid-multiply
      issue(1'b0, 2'b00, 2'b00, 32'h5, 32'h6, 32'd30);
      repeat (5) @(negedge clk_i);
      #2;
      start_i = 1'b0;
      reset_i = 1'b1;
      exp_q.delete();
      model_res = '0;
      #1;
      check("arst_result", result_o, 32'h0);
      check("arst_done", {31'h0, done_o}, 32'h0);
      check("arst_busy", {31'h0, busy_o}, 32'h0);
      @(negedge clk_i);
      #2;
      reset_i = 1'b0;

      run_vec("mul_3_4", 1'b0, 2'b00, 2'b00, 32'd3, 32'd4, 32'd12, 1'b1);

      repeat (3) @(negedge clk_i);
      check("queue_drained", exp_q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit in the EX stage, driven by the decoder's muldiv_start / muldiv_sel / op_mul / op_div outputs.
- Consumes the forwarded rs1/rs2 operands.
- Stalls the pipeline through busy_o while iterating.
- Presents a registered 32-bit result that the EX result mux selects when EX_mux6 = 2'b10.
- Uses one radix-2 shift-add / restoring-divide datapath shared by all eight M-extension operations.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk_i  input  1  core clock
reset_i  input  1  asynchronous, active-high reset
start_i  input  1  muldiv_start from decode, held high while the instruction sits in EX
sel_i  input  1  0 = multiply, 1 = divide (muldiv_sel)
op_mul_i  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
op_div_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
a_i  input  32  rs1 operand (post-forwarding)
b_i  input  32  rs2 operand (post-forwarding)
flush_i  input  1  kill the in-flight operation (branch/trap)
busy_o  output  1  stall request to the hazard unit
done_o  output  1  one-cycle pulse: result_o valid for the instruction in EX
result_o  output  32  registered result

Behaviour:
- Clock/reset: one clock clk_i; reset_i is asynchronous and active-high.
- Reset values: state IDLE, count 0, all datapath registers 0, result_o 0, done_o 0, busy_o 0.
- States:
  - IDLE: start_i=1 and flush_i=0 -> latch operands and op, take magnitudes, record signs, go to BUSY (count=0). Exception: a fast-path divide (see below) goes directly to DONE.
  - BUSY: one iteration per cycle, count increments. At count = XLEN-1 the final iteration runs, then -> DONE.
  - DONE: result_o is loaded on entry and done_o=1 for exactly this cycle; next state is IDLE unconditionally. start_i is ignored in DONE.
- busy_o (combinational):
  - High when (IDLE & start_i & ~flush_i) or BUSY.
  - Low in DONE, so the pipeline advances on the DONE cycle edge.
  - A back-to-back muldiv instruction sees start_i high in IDLE the following cycle and begins normally.
- Latency:
  - Normal op: acceptance edge at cycle 0, BUSY for 32 cycles, done_o high in cycle 33.
  - Fast path: done_o high in cycle 1.
- Signedness:
  - MUL/MULH/DIV/REM treat both operands as signed.
  - MULHSU treats a as signed and b as unsigned.
  - Unsigned variants treat both operands as unsigned.
  - Datapath iterates on magnitudes; signs are corrected at the end.
  - Product sign = sa^sb.
  - Quotient sign = sa^sb; remainder sign = sa (dividend).
- Multiply: 64-bit product. MUL returns [31:0]; MULH/MULHSU/MULHU return [63:32].
- Divide fast paths (no iteration), decided in IDLE:
  - b=0: quotient 0xFFFFFFFF, remainder = a (all variants).
  - Signed overflow, a=0x80000000, b=0xFFFFFFFF, DIV/REM only: quotient 0x80000000, remainder 0.
- flush_i:
  - In IDLE it blocks acceptance.
  - In BUSY or DONE it forces IDLE next edge, suppresses done_o, and leaves result_o unchanged.
- Reset asserted mid-operation: immediate return to reset values; no done_o.
- Operand changes on a_i/b_i after acceptance have no effect.
- result_o holds its value until the next DONE.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: MUL_*, DIV_* localparams for op_mul/op_div;
  - state encoding: IDLE, BUSY, DONE;
  - XLEN default;
  - the fast-path constants DIV0_Q = 32'hFFFFFFFF and OVF_Q = 32'h80000000.
- One natural sub-module, muldiv_signfix (combinational): given operands and op, it produces the magnitudes and sign flags, and it negates the raw unsigned result. It is instantiated for both the input and output stages.
- The FSM, counter and shift/add/subtract datapath stay in muldiv_unit.

Test Plan:
1. MUL a=7, b=0xFFFFFFFD (-3) -> busy_o high cycles 0-32, done_o in cycle 33, result_o=0xFFFFFFEB; busy_o low in the done cycle.
2. MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. DIVU 5/0 -> 0xFFFFFFFF with done_o in cycle 1; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, both in cycle 1.
5. Back-to-back: MUL held with start_i, then a second DIV whose start_i stays high after the first done_o -> second op accepted in IDLE the next cycle; two done pulses 34 cycles apart, each result correct.
6. Interrupts:
   - flush_i at cycle 10 of a DIV -> IDLE next edge, no done_o, result_o unchanged.
   - reset_i pulsed asynchronously mid-MUL (between clock edges) -> outputs zero immediately.
   - A subsequent MUL 3x4 -> 12.
